pipelined_tree_accumulator: RTL

- Parametrised, fully pipelined signed adder tree. Reduces N_INPUTS signed operands per beat to a single sum.
- Adds a frame accumulator so that dot-product partials longer than the tree width are summed over several beats.
- Sits after the ternary vector multiplier in the layer datapath. Takes one multiplier output vector per beat and emits one accumulated neuron pre-activation per frame.
- Adds over the previous generation: valid/ready flow control, non-power-of-two input counts, configurable widths, saturation with overflow flag, and a beat counter.

---
 rtl/pipelined_tree_accumulator_if.sv | 28 ++
 rtl/pipelined_tree_accumulator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_tree_accumulator_if.sv
// Beat-in / result-out handshake bundle for the pipelined tree accumulator.
// The DUT uses the slave modport, and the producer/consumer side uses the master modport.
interface pipelined_tree_accumulator_if #(
    parameter int N_INPUTS  = 4096,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_last;
    logic [N_INPUTS*IN_WIDTH-1:0]  in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [ACC_WIDTH-1:0]   out_sum;
    logic [CNT_WIDTH-1:0]          out_count;
    logic                          out_ovf;

    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/pipelined_tree_accumulator.sv
// Fully pipelined signed adder tree with a saturating per-frame accumulator.
// One multiplier vector is consumed per beat, and one pre-activation sum is emitted per frame.
module pipelined_tree_accumulator #(
    parameter int N_INPUTS  = 4096,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 8
) (
    input logic clk,
    input logic rst,
    pipelined_tree_accumulator_if.slave bus
);

    localparam int LEVELS = $clog2(N_INPUTS);
    localparam int P      = 1 << LEVELS;
    localparam int ROOT_W = IN_WIDTH + LEVELS;

    // Bit offset of tree level l inside the flat node vector (levels 1..LEVELS, level l is IN_WIDTH+l wide)
    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int j = 1; j < l; j++) o += (P >> j) * (IN_WIDTH + j);
        return o;
    endfunction

    localparam int NODE_BITS = lvl_off(LEVELS + 1);

    typedef enum logic {S_FIRST, S_ACCUM} state_t;

    logic                         en;
    logic [NODE_BITS-1:0]         nodes;
    logic [LEVELS:1]              vld_q;
    logic [LEVELS:1]              last_q;
    logic signed [ROOT_W-1:0]     root;
    logic signed [ACC_WIDTH-1:0]  root_ext;
    logic signed [ACC_WIDTH:0]    wide_sum;

    state_t                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic                         ovf_q, ovf_d;
    logic                         done_q, done_d;

    logic                         out_valid_q;
    logic signed [ACC_WIDTH-1:0]  out_sum_q;
    logic [CNT_WIDTH-1:0]         out_cnt_q;
    logic                         out_ovf_q;

    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    // Valid and last flags ride alongside the tree data, stalling with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            last_q <= '0;
        end else if (en) begin
            vld_q[1]  <= bus.in_valid;
            last_q[1] <= bus.in_last;
            for (int l = 2; l <= LEVELS; l++) begin
                vld_q[l]  <= vld_q[l-1];
                last_q[l] <= last_q[l-1];
            end
        end
    end

    genvar l, k;
    for (l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int W    = IN_WIDTH + l;
        localparam int NS   = P >> l;
        localparam int OFF  = lvl_off(l);
        localparam int POFF = lvl_off(l - 1);

        logic signed [W-2:0] opnd [2*NS];
        logic signed [W-1:0] sum_q [NS];

        for (k = 0; k < 2*NS; k++) begin : g_op
            if (l == 1) begin : g_in
                if (k < N_INPUTS) begin : g_real
                    assign opnd[k] = bus.in_data[k*IN_WIDTH +: IN_WIDTH];
                end else begin : g_pad
                    assign opnd[k] = '0;
                end
            end else begin : g_prev
                assign opnd[k] = nodes[POFF + k*(W-1) +: W-1];
            end
        end

        // Each level grows by one bit so that pair sums are exact
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < NS; i++) sum_q[i] <= '0;
            end else if (en) begin
                for (int i = 0; i < NS; i++) sum_q[i] <= W'(opnd[2*i]) + W'(opnd[2*i+1]);
            end
        end

        for (k = 0; k < NS; k++) begin : g_out
            assign nodes[OFF + k*W +: W] = sum_q[k];
        end
    end

    assign root     = nodes[NODE_BITS-ROOT_W +: ROOT_W];
    assign root_ext = ACC_WIDTH'(root);
    assign wide_sum = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(root_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FIRST;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // A disagreement between the top two bits of the widened sum marks overflow, and the top bit gives its direction
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = done_q;
        if (en) begin
            done_d = vld_q[LEVELS] && last_q[LEVELS];
            if (vld_q[LEVELS]) begin
                case (state_q)
                    S_FIRST: begin
                        acc_d = root_ext;
                        cnt_d = CNT_WIDTH'(1);
                        ovf_d = 1'b0;
                    end
                    S_ACCUM: begin
                        if (wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1]) begin
                            acc_d = wide_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = $signed(wide_sum[ACC_WIDTH-1:0]);
                        end
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    end
                    default: begin
                        acc_d = acc_q;
                    end
                endcase
                state_d = last_q[LEVELS] ? S_FIRST : S_ACCUM;
            end
        end
    end

    // The result register loads the finished frame one edge after the accumulator closes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= done_q;
            if (done_q) begin
                out_sum_q <= acc_q;
                out_cnt_q <= cnt_q;
                out_ovf_q <= ovf_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_cnt_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule
